// File: rtl/cv32e40x_tb_status_pkg.sv
// Shared definitions for the testbench status responder: register offsets,
// register-select encoding and the default pass/fail magic values.
package cv32e40x_tb_status_pkg;

  localparam logic [5:0] OFF_PRINT       = 6'h00;
  localparam logic [5:0] OFF_TEST_STATUS = 6'h04;
  localparam logic [5:0] OFF_EXIT        = 6'h08;
  localparam logic [5:0] OFF_CYCLE_LO    = 6'h0C;
  localparam logic [5:0] OFF_CYCLE_HI    = 6'h10;

  localparam logic [31:0] DEFAULT_PASS_VALUE = 32'd123456789;
  localparam logic [31:0] DEFAULT_FAIL_VALUE = 32'd1;

  typedef enum logic [2:0] {
    SEL_PRINT,
    SEL_STATUS,
    SEL_EXIT,
    SEL_CYC_LO,
    SEL_CYC_HI,
    SEL_ERR
  } reg_sel_e;

  // Map a window offset to a register; misaligned or unmapped offsets -> SEL_ERR
  function automatic reg_sel_e decode_offset(input logic [5:0] off);
    reg_sel_e sel;
    sel = SEL_ERR;
    if (off[1:0] == 2'b00) begin
      case (off)
        OFF_PRINT:       sel = SEL_PRINT;
        OFF_TEST_STATUS: sel = SEL_STATUS;
        OFF_EXIT:        sel = SEL_EXIT;
        OFF_CYCLE_LO:    sel = SEL_CYC_LO;
        OFF_CYCLE_HI:    sel = SEL_CYC_HI;
        default:         sel = SEL_ERR;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/cv32e40x_tb_char_fifo.sv
// Small synchronous FIFO buffering stdout characters. Pushes while full and
// pops while empty are dropped; pointers wrap naturally (DEPTH is a power of 2).
module cv32e40x_tb_char_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q];

  // Next-state for storage, pointers and occupancy
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) begin
      mem_d[wptr_q] = wdata_i;
      wptr_d        = wptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
      2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q  <= '{default: '0};
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/cv32e40x_tb_status_responder.sv
// OBI data-bus responder for the core testbench wrapper: virtual peripherals
// for stdout, test status, exit code and a 64-bit cycle counter.
module cv32e40x_tb_status_responder
  import cv32e40x_tb_status_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] PASS_VALUE = DEFAULT_PASS_VALUE,
  parameter logic [31:0] FAIL_VALUE = DEFAULT_FAIL_VALUE
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        char_valid_o,
  output logic [7:0]  char_data_o,
  input  logic        char_ready_i,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o
);

  reg_sel_e    sel;
  logic        in_win;
  logic        print_wr;
  logic        accept;
  logic        fifo_full, fifo_empty;
  logic        push, pop;
  logic        unused_be;

  logic        rvalid_q, rvalid_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        passed_q, passed_d;
  logic        failed_q, failed_d;
  logic        exit_valid_q, exit_valid_d;
  logic [31:0] exit_value_q, exit_value_d;
  logic [63:0] cycle_q, cycle_d;
  logic [31:0] hi_snap_q, hi_snap_d;

  assign unused_be = ^be_i[3:1];

  assign in_win   = (addr_i[31:6] == BASE_ADDR[31:6]);
  assign sel      = in_win ? decode_offset(addr_i[5:0]) : SEL_ERR;
  assign print_wr = we_i & (sel == SEL_PRINT);
  assign gnt_o    = req_i & ~(print_wr & fifo_full);
  assign accept   = req_i & gnt_o;
  assign pop      = ~fifo_empty & char_ready_i;

  // Register access on acceptance: side effects plus the response captured for next cycle
  always_comb begin
    rvalid_d     = accept;
    err_d        = 1'b0;
    rdata_d      = '0;
    passed_d     = passed_q;
    failed_d     = failed_q;
    exit_valid_d = exit_valid_q;
    exit_value_d = exit_value_q;
    hi_snap_d    = hi_snap_q;
    cycle_d      = cycle_q + 64'd1;
    push         = 1'b0;
    if (accept) begin
      case (sel)
        SEL_PRINT: begin
          push = we_i & be_i[0];
        end
        SEL_STATUS: begin
          if (we_i) begin
            if (wdata_i == PASS_VALUE) passed_d = 1'b1;
            if (wdata_i == FAIL_VALUE) failed_d = 1'b1;
          end else begin
            rdata_d = {30'b0, failed_q, passed_q};
          end
        end
        SEL_EXIT: begin
          if (we_i) begin
            if (!exit_valid_q) begin
              exit_valid_d = 1'b1;
              exit_value_d = wdata_i;
            end
          end else begin
            rdata_d = exit_value_q;
          end
        end
        SEL_CYC_LO: begin
          if (!we_i) begin
            rdata_d   = cycle_q[31:0];
            hi_snap_d = cycle_q[63:32];
          end
        end
        SEL_CYC_HI: begin
          if (!we_i) rdata_d = hi_snap_q;
        end
        default: begin
          err_d = 1'b1;
        end
      endcase
    end
  end

  // Response stage, sticky flags, exit latch, counter and HI snapshot
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q     <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      passed_q     <= 1'b0;
      failed_q     <= 1'b0;
      exit_valid_q <= 1'b0;
      exit_value_q <= '0;
      cycle_q      <= '0;
      hi_snap_q    <= '0;
    end else begin
      rvalid_q     <= rvalid_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      passed_q     <= passed_d;
      failed_q     <= failed_d;
      exit_valid_q <= exit_valid_d;
      exit_value_q <= exit_value_d;
      cycle_q      <= cycle_d;
      hi_snap_q    <= hi_snap_d;
    end
  end

  cv32e40x_tb_char_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_char_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (push),
    .wdata_i(wdata_i[7:0]),
    .full_o (fifo_full),
    .pop_i  (pop),
    .rdata_o(char_data_o),
    .empty_o(fifo_empty)
  );

  assign rvalid_o       = rvalid_q;
  assign err_o          = err_q;
  assign rdata_o        = rdata_q;
  assign char_valid_o   = ~fifo_empty;
  assign tests_passed_o = passed_q;
  assign tests_failed_o = failed_q;
  assign exit_valid_o   = exit_valid_q;
  assign exit_value_o   = exit_value_q;

endmodule

// File: tb/tb_cv32e40x_tb_status_responder.sv
// Randomized scoreboard bench for the status responder: stimulus pushes
// expected responses, separate monitors check OBI responses and the char stream.
module tb_cv32e40x_tb_status_responder;

  localparam logic [31:0] BASE   = 32'h2000_0000;
  localparam int          DEPTH  = 8;
  localparam logic [31:0] PASS_V = 32'd123456789;
  localparam logic [31:0] FAIL_V = 32'd1;

  logic        clk_i, rst_ni;
  logic        req_i, gnt_o, we_i;
  logic [31:0] addr_i, wdata_i, rdata_o, exit_value_o;
  logic [3:0]  be_i;
  logic        rvalid_o, err_o;
  logic        char_valid_o, char_ready_i;
  logic [7:0]  char_data_o;
  logic        tests_passed_o, tests_failed_o, exit_valid_o;

  cv32e40x_tb_status_responder #(
    .BASE_ADDR (BASE),
    .FIFO_DEPTH(DEPTH),
    .PASS_VALUE(PASS_V),
    .FAIL_VALUE(FAIL_V)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o),
    .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .char_valid_o(char_valid_o), .char_data_o(char_data_o), .char_ready_i(char_ready_i),
    .tests_passed_o(tests_passed_o), .tests_failed_o(tests_failed_o),
    .exit_valid_o(exit_valid_o), .exit_value_o(exit_value_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic        is_read;
    longint      due;
  } rsp_t;

  rsp_t        sb_q[$];
  logic [7:0]  m_chars[$];
  logic        m_passed, m_failed, m_exit_valid;
  logic [31:0] m_exit_val, m_hi;
  logic [63:0] tb_cyc;
  longint      edge_n = 0;
  logic        cyc_force_en = 1'b0;
  logic [63:0] cyc_force_val = '0;
  logic        rdy_rand = 1'b0;
  logic        rdy_val = 1'b0;

  // Cycles elapsed since reset release, as the counter should see them
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tb_cyc <= '0;
    else         tb_cyc <= tb_cyc + 64'd1;
  end

  always @(posedge clk_i) edge_n <= edge_n + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    sb_q.delete();
    m_chars.delete();
    m_passed = 1'b0; m_failed = 1'b0; m_exit_valid = 1'b0;
    m_exit_val = '0; m_hi = '0;
  endtask

  function automatic bit is_print(input logic [31:0] a);
    return (a[31:6] == BASE[31:6]) && (a[5:0] == 6'h00);
  endfunction

  // Reference model of one accepted transfer, written from the register map
  task automatic model_accept(input logic [31:0] a, input logic w, input logic [3:0] b,
                              input logic [31:0] d);
    rsp_t        r;
    logic [5:0]  off;
    logic [63:0] cur;
    off = a[5:0];
    cur = cyc_force_en ? cyc_force_val : tb_cyc;
    r.err = (a[31:6] != BASE[31:6]) || (off[1:0] != 2'b00) || (off > 6'h10);
    r.rdata = '0;
    r.is_read = !w;
    r.due = edge_n + 1;
    if (!r.err) begin
      case (off)
        6'h00: if (w && b[0]) m_chars.push_back(d[7:0]);
        6'h04: begin
          if (w) begin
            if (d == PASS_V) m_passed = 1'b1;
            if (d == FAIL_V) m_failed = 1'b1;
          end else r.rdata = {30'b0, m_failed, m_passed};
        end
        6'h08: begin
          if (w) begin
            if (!m_exit_valid) begin m_exit_valid = 1'b1; m_exit_val = d; end
          end else r.rdata = m_exit_val;
        end
        6'h0C: if (!w) begin r.rdata = cur[31:0]; m_hi = cur[63:32]; end
        6'h10: if (!w) r.rdata = m_hi;
        default: ;
      endcase
    end
    sb_q.push_back(r);
  endtask

  // One bus cycle; entered and left at a falling clock edge
  task automatic step(input bit rq, input logic [31:0] a, input logic w, input logic [3:0] b,
                      input logic [31:0] d, output bit granted);
    logic exp_gnt;
    #1;
    req_i = rq; addr_i = a; we_i = w; be_i = b; wdata_i = d;
    char_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
    #1;
    granted = 1'b0;
    if (rq) begin
      exp_gnt = !(w && is_print(a) && (m_chars.size() == DEPTH));
      chk("gnt", {63'b0, gnt_o}, {63'b0, exp_gnt});
      if (gnt_o) begin
        granted = 1'b1;
        model_accept(a, w, b, d);
      end
    end
    @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    bit g;
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0, g);
  endtask

  task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] b,
                       input logic [31:0] d);
    bit g;
    int n;
    n = 0;
    do begin
      step(1'b1, a, w, b, d, g);
      n++;
    end while (!g && n < 50);
    if (!g) begin
      checks++; failures++;
      $display("FAIL issue_timeout addr=%0h actual=no_grant required=grant", a);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"}, {63'b0, gnt_o}, 64'd0);
    chk({tag, "_rvalid"}, {63'b0, rvalid_o}, 64'd0);
    chk({tag, "_rdata"}, {32'b0, rdata_o}, 64'd0);
    chk({tag, "_err"}, {63'b0, err_o}, 64'd0);
    chk({tag, "_char_valid"}, {63'b0, char_valid_o}, 64'd0);
    chk({tag, "_char_data"}, {56'b0, char_data_o}, 64'd0);
    chk({tag, "_passed"}, {63'b0, tests_passed_o}, 64'd0);
    chk({tag, "_failed"}, {63'b0, tests_failed_o}, 64'd0);
    chk({tag, "_exit_valid"}, {63'b0, exit_valid_o}, 64'd0);
    chk({tag, "_exit_value"}, {32'b0, exit_value_o}, 64'd0);
  endtask

  // Response monitor: pops the scoreboard whenever the DUT answers
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk_i);
      if (rst_ni) begin
        if (rvalid_o) begin
          if (sb_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL spurious_rvalid actual=rvalid required=idle at %0t", $time);
          end else begin
            r = sb_q.pop_front();
            chk("rsp_cycle", edge_n, r.due);
            chk("rsp_err", {63'b0, err_o}, {63'b0, r.err});
            if (r.is_read || r.err) chk("rsp_rdata", {32'b0, rdata_o}, {32'b0, r.rdata});
            chk("passed", {63'b0, tests_passed_o}, {63'b0, m_passed});
            chk("failed", {63'b0, tests_failed_o}, {63'b0, m_failed});
            chk("exit_valid", {63'b0, exit_valid_o}, {63'b0, m_exit_valid});
            chk("exit_value", {32'b0, exit_value_o}, {32'b0, m_exit_val});
          end
        end else begin
          chk("rdata_idle", {32'b0, rdata_o}, 64'd0);
          if (sb_q.size() != 0 && sb_q[0].due < edge_n) begin
            r = sb_q.pop_front();
            checks++; failures++;
            $display("FAIL missing_rvalid actual=none required=response_due_%0d", r.due);
          end
        end
      end
    end
  end

  // Character stream monitor, sampled just before the edge that pops
  initial begin
    forever begin
      @(negedge clk_i);
      #4;
      if (rst_ni && char_valid_o) begin
        if (m_chars.size() == 0) begin
          checks++; failures++;
          $display("FAIL spurious_char actual=%0h required=none", char_data_o);
        end else begin
          chk("char_data", {56'b0, char_data_o}, {56'b0, m_chars[0]});
          if (char_ready_i) void'(m_chars.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit g;
    logic [31:0] a, d;
    logic w;
    int k;
    rst_ni = 1'b0; req_i = 1'b0; addr_i = '0; we_i = 1'b0; be_i = '0; wdata_i = '0;
    char_ready_i = 1'b0;
    reset_model();
    repeat (3) @(negedge clk_i);
    check_all_zero("reset");
    #1 rst_ni = 1'b1;
    @(negedge clk_i);

    // Single character print
    rdy_val = 1'b1;
    issue(BASE, 1'b1, 4'hF, 32'h0000_0041);
    chk("print_char_valid", {63'b0, char_valid_o}, 64'd1);
    chk("print_char_data", {56'b0, char_data_o}, 64'h41);
    idle(2);

    // Fill the FIFO with the consumer stalled, then release it
    rdy_val = 1'b0;
    for (int i = 0; i < 8; i++) issue(BASE, 1'b1, 4'hF, 32'h61 + i);
    for (int i = 0; i < 3; i++) step(1'b1, BASE, 1'b1, 4'hF, 32'h69, g);
    rdy_val = 1'b1;
    issue(BASE, 1'b1, 4'hF, 32'h69);
    issue(BASE, 1'b1, 4'hE, 32'h7A);
    idle(12);
    chk("fifo_drained", {63'b0, char_valid_o}, 64'd0);

    // Test status flags and exit code
    issue(BASE + 32'h4, 1'b1, 4'hF, PASS_V);
    issue(BASE + 32'h4, 1'b1, 4'hF, 32'h0000_0007);
    issue(BASE + 32'h4, 1'b1, 4'hF, FAIL_V);
    issue(BASE + 32'h4, 1'b0, 4'hF, '0);
    issue(BASE + 32'h8, 1'b1, 4'hF, 32'h5);
    issue(BASE + 32'h8, 1'b1, 4'hF, 32'h0);
    issue(BASE + 32'h8, 1'b0, 4'hF, '0);
    idle(1);
    chk("status_passed", {63'b0, tests_passed_o}, 64'd1);
    chk("status_failed", {63'b0, tests_failed_o}, 64'd1);
    chk("exit_code", {32'b0, exit_value_o}, 64'd5);

    // Error responses and read-only writes
    issue(BASE + 32'h20, 1'b0, 4'hF, '0);
    issue(BASE + 32'h02, 1'b0, 4'hF, '0);
    issue(32'h3000_0000, 1'b1, 4'hF, 32'h1234);
    issue(BASE + 32'hC, 1'b1, 4'hF, 32'hFFFF);
    issue(BASE + 32'hC, 1'b0, 4'hF, '0);
    issue(BASE + 32'h10, 1'b0, 4'hF, '0);
    idle(2);

    // Randomized traffic with a randomly stalling consumer
    rdy_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 9);
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      case (k)
        0, 1, 2, 3, 4: a = BASE + 32'(4 * k);
        5:             a = BASE + 32'(4 * $urandom_range(5, 15));
        6:             a = BASE + 32'(($urandom_range(0, 15) << 2) | $urandom_range(1, 3));
        7:             a = BASE + 32'h40 + 32'($urandom_range(0, 1023));
        default:       a = BASE;
      endcase
      if (k == 1) begin
        case ($urandom_range(0, 3))
          0: d = PASS_V;
          1: d = FAIL_V;
          default: ;
        endcase
      end
      if ($urandom_range(0, 4) == 0) idle(1);
      issue(a, w, 4'($urandom), d);
    end
    rdy_rand = 1'b0;
    rdy_val = 1'b1;
    idle(12);
    chk("rand_chars_left", 64'(m_chars.size()), 64'd0);
    chk("rand_char_valid", {63'b0, char_valid_o}, 64'd0);

    // Coherent 64-bit counter read across a low-word wrap
    force dut.cycle_q = 64'h0000_0000_FFFF_FFFF;
    cyc_force_en = 1'b1;
    cyc_force_val = 64'h0000_0000_FFFF_FFFF;
    step(1'b1, BASE + 32'hC, 1'b0, 4'hF, '0, g);
    release dut.cycle_q;
    cyc_force_en = 1'b0;
    step(1'b1, BASE + 32'h10, 1'b0, 4'hF, '0, g);
    idle(2);

    // Reset in the cycle after a granted write drops its response
    rdy_val = 1'b0;
    #1;
    req_i = 1'b1; addr_i = BASE; we_i = 1'b1; be_i = 4'hF; wdata_i = 32'h5A;
    char_ready_i = 1'b0;
    #1;
    chk("rst_gnt", {63'b0, gnt_o}, 64'd1);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    req_i = 1'b0;
    reset_model();
    @(negedge clk_i);
    check_all_zero("midreset");
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    idle(4);
    issue(BASE + 32'hC, 1'b0, 4'hF, '0);
    issue(BASE + 32'h4, 1'b0, 4'hF, '0);
    idle(3);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
